cache_ctrl_2way_wt: RTL

FSM controller that owns the tag/valid/LRU state and data array of the 2-way set-associative, write-through cache. Sequences CPU reads and writes against a multi-cycle main-memory port with a req/ack handshake. Sits between the single-cycle-processor memory stage and the main memory model. Policy: LRU replacement, write-through, no-write-allocate.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/cache_tag_store.sv | 54 +++++
 rtl/cache_ctrl_2way_wt.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and address field helpers for the 2-way write-through cache.
package cache_pkg;

  localparam int ADDR_W          = 10;
  localparam int DATA_W          = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int NUM_SETS        = 2;
  localparam int NUM_WAYS        = 2;
  localparam int TAG_W           = 5;
  localparam int INDEX_W         = 1;
  localparam int OFFSET_W        = 4;
  localparam int BLOCK_W         = 128;
  localparam int WORD_SEL_W      = 2;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    REFILL,
    WRITE_MEM
  } state_t;

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] index_of(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [WORD_SEL_W-1:0] word_of(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W-1 -: WORD_SEL_W];
  endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Valid/tag/LRU state for both ways of every set, with combinational lookup and victim choice.
module cache_tag_store
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  output logic               hit,
  output logic               hit_way,
  output logic               victim_way,
  input  logic               fill_en,
  input  logic               fill_way,
  input  logic               touch_en,
  input  logic               touch_way
);

  logic [NUM_SETS-1:0][NUM_WAYS-1:0]            valid_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0][TAG_W-1:0] tag_q;
  logic [NUM_SETS-1:0]                          lru_q;
  logic [NUM_WAYS-1:0]                          match;

  always_comb begin
    match = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w] = valid_q[index][w] && (tag_q[index][w] == tag);
    end
    hit     = |match;
    hit_way = match[1];
    // Empty ways are filled before anything valid is evicted.
    if (!valid_q[index][0]) begin
      victim_way = 1'b0;
    end else if (!valid_q[index][1]) begin
      victim_way = 1'b1;
    end else begin
      victim_way = lru_q[index];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      tag_q   <= '0;
      lru_q   <= '0;
    end else if (fill_en) begin
      valid_q[index][fill_way] <= 1'b1;
      tag_q[index][fill_way]   <= tag;
      lru_q[index]             <= ~fill_way;
    end else if (touch_en) begin
      lru_q[index] <= ~touch_way;
    end
  end

endmodule

// File: rtl/cache_ctrl_2way_wt.sv
// 2-way set-associative write-through, no-write-allocate cache controller with LRU replacement.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
//
// state     | meaning
// IDLE      | waiting for cpu_req; request fields latched on acceptance
// COMPARE   | tag lookup; read hit completes, read miss starts refill, writes go to memory
// REFILL    | block read outstanding; on mem_ack fill victim and replay COMPARE
// WRITE_MEM | write-through word outstanding; on mem_ack complete the access
module cache_ctrl_2way_wt
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cpu_ready,
  output logic               cpu_hit,
  output logic               cpu_busy,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  orig_hit_q, orig_hit_d;

  logic [DATA_W-1:0]     cpu_rdata_d, mem_wdata_d;
  logic                  cpu_ready_d, cpu_hit_d, mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_d;

  logic [BLOCK_W-1:0]    data_q [NUM_WAYS][NUM_SETS];
  logic [BLOCK_W-1:0]    data_blk, cur_blk;
  logic                  data_we, data_way;

  logic [INDEX_W-1:0]    idx;
  logic [WORD_SEL_W-1:0] word;
  logic                  hit, hit_way, victim_way, fill_en, touch_en;

  assign idx      = index_of(addr_q);
  assign word     = word_of(addr_q);
  assign cur_blk  = data_q[hit_way][idx];
  assign cpu_busy = (state_q != IDLE);

  cache_tag_store u_tag_store (
    .clk        (clk),
    .reset      (reset),
    .index      (idx),
    .tag        (tag_of(addr_q)),
    .hit        (hit),
    .hit_way    (hit_way),
    .victim_way (victim_way),
    .fill_en    (fill_en),
    .fill_way   (victim_way),
    .touch_en   (touch_en),
    .touch_way  (hit_way)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    orig_hit_d  = orig_hit_q;
    cpu_rdata_d = cpu_rdata;
    cpu_ready_d = 1'b0;
    cpu_hit_d   = 1'b0;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    fill_en     = 1'b0;
    touch_en    = 1'b0;
    data_we     = 1'b0;
    data_way    = hit_way;
    data_blk    = cur_blk;

    unique case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d       = cpu_we;
          addr_d     = cpu_addr;
          wdata_d    = cpu_wdata;
          orig_hit_d = 1'b1;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        if (!we_q) begin
          if (hit) begin
            cpu_rdata_d = cur_blk[int'(word)*DATA_W +: DATA_W];
            cpu_ready_d = 1'b1;
            cpu_hit_d   = orig_hit_q;
            touch_en    = 1'b1;
            state_d     = IDLE;
          end else begin
            orig_hit_d = 1'b0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = addr_q & ADDR_W'(10'h3F0);
            state_d    = REFILL;
          end
        end else begin
          orig_hit_d = hit;
          if (hit) begin
            data_we  = 1'b1;
            data_blk[int'(word)*DATA_W +: DATA_W] = wdata_q;
            touch_en = 1'b1;
          end
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q & ADDR_W'(10'h3FC);
          mem_wdata_d = wdata_q;
          state_d     = WRITE_MEM;
        end
      end
      REFILL: begin
        if (mem_ack) begin
          fill_en   = 1'b1;
          data_we   = 1'b1;
          data_way  = victim_way;
          data_blk  = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = COMPARE;
        end
      end
      WRITE_MEM: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          cpu_ready_d = 1'b1;
          cpu_hit_d   = orig_hit_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      orig_hit_q <= 1'b0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      cpu_hit    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      orig_hit_q <= orig_hit_d;
      cpu_rdata  <= cpu_rdata_d;
      cpu_ready  <= cpu_ready_d;
      cpu_hit    <= cpu_hit_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          data_q[w][s] <= '0;
        end
      end
    end else if (data_we) begin
      data_q[data_way][idx] <= data_blk;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (cpu_ready_d) begin
      if (cpu_hit_d) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
